// File: rtl/trng_pkg.sv
// Shared constants and types for the TRNG post-processing block.
// Holds the parameter defaults, the byte width and the von Neumann corrector state encoding.
package trng_pkg;

  localparam int BYTE_W         = 8;
  localparam int RCT_CUTOFF_DEF = 32;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    VN_EMPTY = 1'b0,
    VN_HALF  = 1'b1
  } vn_state_t;

endpackage

// File: rtl/trng_byte_fifo.sv
// Small byte FIFO with flush, holding packed random bytes until the consumer drains them.
// The head byte is read combinationally from the storage array.
module trng_byte_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_push;
  logic              w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/trng_postproc.sv
// TRNG post-processing: decimation, parity fold, repetition-count health test,
// von Neumann debiasing and LSB-first byte packing into a drainable FIFO.
module trng_postproc
  import trng_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [15:0]       raw_in,
  input  logic              health_clr,
  output logic              ro_en,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              health_fail,
  output logic              overflow
);

  logic              r_ro_en;
  logic              r_health_fail;
  logic              r_overflow;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  w_div_max;
  logic              w_strobe;
  logic              r_s1_valid;
  logic              r_s1_bit;
  logic              w_take;
  logic [7:0]        r_rct_cnt;
  logic [7:0]        w_rct_next;
  logic              r_prev_bit;
  logic              w_hf_set;
  vn_state_t         r_vn_state;
  vn_state_t         w_vn_next;
  logic              r_vn_bit;
  logic              w_vn_emit;
  logic              w_vn_clr;
  logic [BYTE_W-1:0] r_pack;
  logic [2:0]        r_pack_cnt;
  logic [BYTE_W-1:0] w_pack_byte;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_ovf_set;

  assign w_div_max = (sample_div == '0) ? '0 : sample_div - DIV_W'(1);
  assign w_strobe  = r_ro_en && (r_div_cnt == w_div_max);
  // An S1 sample is dropped if enable has fallen or the health test has tripped.
  assign w_take    = r_s1_valid && enable && !r_health_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_bit   <= 1'b0;
    end else begin
      r_s1_valid <= w_strobe;
      if (w_strobe) r_s1_bit <= ^raw_in;
      if (!r_ro_en || w_strobe) r_div_cnt <= '0;
      else                      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    w_rct_next = 8'd1;
    if ((r_rct_cnt != 8'd0) && (r_s1_bit == r_prev_bit))
      w_rct_next = (r_rct_cnt == 8'hFF) ? r_rct_cnt : r_rct_cnt + 8'd1;
  end

  assign w_hf_set = w_take && (w_rct_next == 8'(RCT_CUTOFF)) && !health_clr;

  // A zero count marks "no previous bit", so the next bit restarts the run at 1.
  always_ff @(posedge clk) begin
    if (!rst_n || health_clr || !enable) begin
      r_rct_cnt  <= 8'd0;
      r_prev_bit <= 1'b0;
    end else if (w_take) begin
      r_rct_cnt  <= w_rct_next;
      r_prev_bit <= r_s1_bit;
    end
  end

  assign w_vn_clr = !enable || w_hf_set;

  always_ff @(posedge clk) begin
    if (!rst_n || w_vn_clr) r_vn_state <= VN_EMPTY;
    else                    r_vn_state <= w_vn_next;
  end

  always_comb begin
    w_vn_next = r_vn_state;
    if (w_take) begin
      case (r_vn_state)
        VN_EMPTY: w_vn_next = VN_HALF;
        VN_HALF:  w_vn_next = VN_EMPTY;
        default:  w_vn_next = VN_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_vn_emit = w_take && (r_vn_state == VN_HALF) && (r_vn_bit != r_s1_bit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                  r_vn_bit <= 1'b0;
    else if (w_take && (r_vn_state == VN_EMPTY)) r_vn_bit <= r_s1_bit;
  end

  always_comb begin
    w_pack_byte             = r_pack;
    w_pack_byte[r_pack_cnt] = r_vn_bit;
  end

  assign w_push = w_vn_emit && (r_pack_cnt == 3'd7) && !w_vn_clr;

  always_ff @(posedge clk) begin
    if (!rst_n || w_vn_clr) begin
      r_pack     <= '0;
      r_pack_cnt <= 3'd0;
    end else if (w_vn_emit) begin
      r_pack     <= w_pack_byte;
      r_pack_cnt <= r_pack_cnt + 3'd1;
    end
  end

  assign w_pop     = out_ready && !w_empty;
  assign w_ovf_set = w_push && w_full && !w_pop;

  trng_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_hf_set),
    .i_push  (w_push),
    .i_data  (w_pack_byte),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ro_en       <= 1'b0;
      r_health_fail <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_ro_en <= enable && !r_health_fail;
      if (health_clr)    r_health_fail <= 1'b0;
      else if (w_hf_set) r_health_fail <= 1'b1;
      if (health_clr)     r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  assign ro_en       = r_ro_en;
  assign out_valid   = !w_empty;
  assign health_fail = r_health_fail;
  assign overflow    = r_overflow;

endmodule

// File: doc/trng_postproc.md
Name: trng_postproc

Overview:
Downstream consumer of the 16-bit raw XOR sample word from the dual ring-oscillator stage. It decimates the samples and folds each one to a single bit by parity. It also runs a repetition-count health test, removes bias with a von Neumann corrector, and packs the surviving bits into bytes. Bytes go into a small FIFO drained over a valid/ready interface. It also gates the oscillator enables upstream.

Parameters:
DIV_W, 8, width of sample_div and of the decimation counter
RCT_CUTOFF, 32, consecutive identical folded bits that trip the health failure (legal range 2..255)
FIFO_DEPTH, 4, byte FIFO entries (power of two, min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  run post-processing; low = idle
sample_div  in  DIV_W  sample every sample_div cycles; 0 treated as 1
raw_in  in  16  raw XOR sample word from the oscillator stage
health_clr  in  1  one-cycle pulse; clears health_fail and overflow
ro_en  out  1  oscillator activate request (drives both ro_activate inputs)
out_data  out  8  FIFO head byte
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data this cycle
health_fail  out  1  sticky repetition-count failure
overflow  out  1  sticky, a packed byte was dropped on a full FIFO

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low on rst_n, sampled only at the posedge of clk.
- Reset values (rst_n low at a clk edge): all counters and state are 0, the FIFO is empty, and all outputs are 0. Outputs are out_data=0, out_valid=0, ro_en=0, health_fail=0 and overflow=0.
- ro_en = enable & ~health_fail. It is registered, so it follows with one cycle of latency.
- Decimation:
  - div_cnt counts only while ro_en=1.
  - When div_cnt == max(sample_div,1)-1, a sample strobe fires and div_cnt wraps to 0.
  - On the strobe, fold bit b = XOR of all 16 raw_in bits, registered one cycle later (stage S1).
  - When ro_en=0, div_cnt is held at 0.
  - A change of sample_div takes effect at the next compare.
- Repetition-count test (on every S1 bit):
  - If b equals the previous bit, rct_cnt increments (saturating); otherwise rct_cnt = 1.
  - When rct_cnt reaches RCT_CUTOFF, health_fail sets in the same cycle the count is written.
  - The first bit after reset, enable rise or health_clr starts rct_cnt at 1.
- Von Neumann corrector (S1 bits, paired):
  - State EMPTY: store b and go to HALF.
  - State HALF: if stored != b, emit the stored bit; otherwise emit nothing. Return to EMPTY.
  - Pairs never overlap.
- Packer:
  - Emitted bits shift in LSB-first, so the first emitted bit lands in out_data[0].
  - At the 8th bit the byte is pushed in the same cycle, and the bit count returns to 0.
- FIFO:
  - Push when a byte completes and the FIFO is not full. If it is full, the byte is dropped and overflow sets.
  - Pop when out_valid & out_ready.
  - A simultaneous push and pop on a full FIFO is allowed: no drop, and occupancy is unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Push-to-out_valid latency is 1 cycle.
- Health failure:
  - On the cycle health_fail sets, the FIFO is flushed (out_valid=0 next cycle), and the VN state and packer are cleared.
  - No pushes occur while health_fail=1.
  - health_clr clears health_fail, overflow and rct_cnt. If it coincides with a set condition, the clear wins.
- enable low:
  - Clears the VN state, the packer partial byte and rct_cnt.
  - The FIFO is retained and can still be drained.
  - A sample already in S1 when enable falls is discarded.
- raw_in is treated as asynchronous data. Its metastability is accepted as part of the entropy, so no synchronizer is added.

Decomposition:
- Package trng_pkg: the RCT_CUTOFF and FIFO_DEPTH defaults, the VN state encoding (VN_EMPTY, VN_HALF) and the byte width constant.
- One sub-module, trng_byte_fifo: parameterised depth, push/pop/flush, full/empty, synchronous active-low reset.
- Decimation, RCT, VN and packer stay inline in trng_postproc.

Test Plan:
- Reset with rst_n=0 for 2 cycles while enable=1 → all outputs 0. The cycle after rst_n=1, ro_en=1.
- sample_div=3, raw_in parity pattern giving S1 bits 1,0,0,1 repeated 8 times, out_ready=1 → one byte per 16 samples. Each byte is 0x55 (VN emits 1,0 per 4 bits, LSB-first), and out_valid pulses every 48 cycles.
- raw_in held at 16'h0001 (parity 1), RCT_CUTOFF=32 → health_fail=1 after the 32nd sample, the FIFO flushes, and ro_en=0 the next cycle. A health_clr pulse restores ro_en=1.
- out_ready=0 with alternating-pair stimulus until 5 bytes are produced, FIFO_DEPTH=4 → out_valid stays high, out_data holds the first byte, and overflow=1 after the 5th byte. Raising out_ready then drains exactly 4 bytes in order.
- Equal pairs only (S1 bits 1,1,0,0 repeating) → no bytes are ever produced and health_fail stays 0.
- enable dropped after 5 emitted bits, then re-raised → the partial byte is discarded, and the next byte contains only post-re-enable bits.
